// File: rtl/distortion_scheduler_if.sv
// Stereo sample/parameter bus for the distortion scheduler.
// The master drives samples and parameter loads; the slave returns processed samples and status.
interface distortion_scheduler_if;
  logic                sampleValid;
  logic signed [15:0]  leftSampleIn;
  logic signed [15:0]  rightSampleIn;
  logic                paramLoad;
  logic signed [15:0]  gainIn;
  logic signed [31:0]  thresholdIn;
  logic [1:0]          modeIn;
  logic signed [15:0]  leftSampleOut;
  logic signed [15:0]  rightSampleOut;
  logic                outValid;
  logic                busy;
  logic                overrun;
  logic signed [15:0]  activeGain;

  modport master (
    output sampleValid, leftSampleIn, rightSampleIn, paramLoad, gainIn, thresholdIn, modeIn,
    input  leftSampleOut, rightSampleOut, outValid, busy, overrun, activeGain
  );

  modport slave (
    input  sampleValid, leftSampleIn, rightSampleIn, paramLoad, gainIn, thresholdIn, modeIn,
    output leftSampleOut, rightSampleOut, outValid, busy, overrun, activeGain
  );
endinterface

// File: rtl/distortion_scheduler.sv
// Four-cycle stereo gain/clip/rectify scheduler sharing one signed multiplier between channels.
// Parameters are captured into shadow registers and committed only when a sample is accepted.
module distortion_scheduler #(
  parameter int GAIN_STEP = 4,
  parameter int MAX_GAIN  = 128
) (
  input logic                  clk,
  input logic                  reset,
  distortion_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL_L, MUL_R, OUT} state_t;

  localparam logic signed [15:0] MAX_G   = 16'(MAX_GAIN);
  localparam logic signed [16:0] STEP    = 17'(GAIN_STEP);
  localparam logic signed [31:0] THR_MAX = 32'sd32767;

  state_t             state_reg;
  logic signed [15:0] samp_reg [2];
  logic signed [31:0] prod_reg [2];
  logic signed [15:0] out_reg  [2];
  logic signed [15:0] shaped   [2];
  logic               out_valid_reg;
  logic               overrun_reg;

  logic signed [15:0] shadow_gain_reg, active_gain_reg;
  logic signed [31:0] shadow_thr_reg, thr_reg;
  logic [1:0]         shadow_mode_reg, mode_reg;

  logic signed [15:0] shadow_gain_next;
  logic signed [31:0] shadow_thr_next;
  logic [1:0]         shadow_mode_next;
  logic signed [15:0] active_gain_next;
  logic signed [16:0] act_ext, tgt_ext, gain_up, gain_dn;
  logic signed [15:0] mul_a;
  logic signed [31:0] mul_p;
  logic signed [31:0] thr_sat;

  // A load on the same edge as a strobe must be visible to that sample, so commit uses the _next values.
  always_comb begin
    shadow_gain_next = shadow_gain_reg;
    shadow_thr_next  = shadow_thr_reg;
    shadow_mode_next = shadow_mode_reg;
    if (bus.paramLoad) begin
      if (bus.gainIn < 16'sd0)
        shadow_gain_next = '0;
      else if (bus.gainIn > MAX_G)
        shadow_gain_next = MAX_G;
      else
        shadow_gain_next = bus.gainIn;
      shadow_thr_next  = (bus.thresholdIn < 32'sd0) ? '0 : bus.thresholdIn;
      shadow_mode_next = bus.modeIn;
    end
  end

  // Ramp one step toward the target in either direction, landing exactly on it.
  always_comb begin
    act_ext = {active_gain_reg[15], active_gain_reg};
    tgt_ext = {shadow_gain_next[15], shadow_gain_next};
    gain_up = act_ext + STEP;
    gain_dn = act_ext - STEP;
    active_gain_next = active_gain_reg;
    if (act_ext < tgt_ext)
      active_gain_next = (gain_up > tgt_ext) ? shadow_gain_next : gain_up[15:0];
    else if (act_ext > tgt_ext)
      active_gain_next = (gain_dn < tgt_ext) ? shadow_gain_next : gain_dn[15:0];
  end

  always_comb begin
    mul_a   = (state_reg == MUL_L) ? samp_reg[0] : samp_reg[1];
    mul_p   = 32'(mul_a) * 32'(active_gain_reg);
    thr_sat = (thr_reg > THR_MAX) ? THR_MAX : thr_reg;
  end

  function automatic logic signed [15:0] shape(
    input logic [1:0]         mode,
    input logic signed [15:0] x,
    input logic signed [31:0] p,
    input logic signed [31:0] thr
  );
    logic signed [31:0] neg_thr;
    neg_thr = -thr;
    shape   = x;
    case (mode)
      2'd0: shape = x;
      2'd2: shape = (x < 16'sd0) ? 16'sd0 : x;
      default: begin
        if (p > thr)
          shape = thr[15:0];
        else if (p < neg_thr)
          shape = neg_thr[15:0];
        else if (p > 32'sd32767)
          shape = 16'sh7fff;
        else if (p < -32'sd32768)
          shape = 16'sh8000;
        else
          shape = p[15:0];
      end
    endcase
  endfunction

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      assign shaped[gi] = shape(mode_reg, samp_reg[gi], prod_reg[gi], thr_sat);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      out_valid_reg   <= 1'b0;
      overrun_reg     <= 1'b0;
      shadow_gain_reg <= '0;
      active_gain_reg <= '0;
      shadow_thr_reg  <= THR_MAX;
      thr_reg         <= THR_MAX;
      shadow_mode_reg <= '0;
      mode_reg        <= '0;
      for (int i = 0; i < 2; i++) begin
        samp_reg[i] <= '0;
        prod_reg[i] <= '0;
        out_reg[i]  <= '0;
      end
    end else begin
      out_valid_reg   <= 1'b0;
      overrun_reg     <= 1'b0;
      shadow_gain_reg <= shadow_gain_next;
      shadow_thr_reg  <= shadow_thr_next;
      shadow_mode_reg <= shadow_mode_next;
      case (state_reg)
        IDLE: begin
          if (bus.sampleValid) begin
            samp_reg[0]     <= bus.leftSampleIn;
            samp_reg[1]     <= bus.rightSampleIn;
            active_gain_reg <= active_gain_next;
            thr_reg         <= shadow_thr_next;
            mode_reg        <= shadow_mode_next;
            state_reg       <= MUL_L;
          end
        end
        MUL_L: begin
          prod_reg[0] <= mul_p;
          overrun_reg <= bus.sampleValid;
          state_reg   <= MUL_R;
        end
        MUL_R: begin
          prod_reg[1] <= mul_p;
          overrun_reg <= bus.sampleValid;
          state_reg   <= OUT;
        end
        OUT: begin
          out_reg[0]    <= shaped[0];
          out_reg[1]    <= shaped[1];
          out_valid_reg <= 1'b1;
          overrun_reg   <= bus.sampleValid;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.leftSampleOut  = out_reg[0];
  assign bus.rightSampleOut = out_reg[1];
  assign bus.outValid       = out_valid_reg;
  assign bus.overrun        = overrun_reg;
  assign bus.busy           = (state_reg != IDLE);
  assign bus.activeGain     = active_gain_reg;

endmodule

// File: tb/tb_distortion_scheduler.sv
// Directed bench for distortion_scheduler: scoreboard of expected stereo outputs,
// fixed-latency, busy and overrun checks, parameter commit/ramp and reset abort.
module tb_distortion_scheduler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  distortion_scheduler_if bus();

  distortion_scheduler #(.GAIN_STEP(4), .MAX_GAIN(128)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int txn    = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic signed [15:0] g, input logic signed [31:0] thr, input logic [1:0] m);
    bus.paramLoad   = 1'b1;
    bus.gainIn      = g;
    bus.thresholdIn = thr;
    bus.modeIn      = m;
    @(negedge clk);
    bus.paramLoad   = 1'b0;
  endtask

  // Strobe one sample now (caller sits at a negedge) and follow it for five cycles.
  task automatic do_sample(input logic signed [15:0] l, input logic signed [15:0] r,
                           input logic signed [15:0] el, input logic signed [15:0] er,
                           input logic signed [15:0] eg, input bit mid_load, input bit mid_valid);
    logic [31:0] e;
    exp_q.push_back({el, er});
    bus.sampleValid   = 1'b1;
    bus.leftSampleIn  = l;
    bus.rightSampleIn = r;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("outvalid", bus.outValid, (k == 4));
      check("busy", bus.busy, (k <= 3));
      check("overrun", bus.overrun, (mid_valid && k == 3));
      if (k == 4) begin
        check("sb_pending", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("left_out", bus.leftSampleOut, $signed(e[31:16]));
          check("right_out", bus.rightSampleOut, $signed(e[15:0]));
        end
        check("active_gain", bus.activeGain, eg);
        txn++;
        $display("txn %0d: in (%0d,%0d) out (%0d,%0d) gain %0d", txn, l, r,
                 bus.leftSampleOut, bus.rightSampleOut, bus.activeGain);
      end
      bus.sampleValid = (mid_valid && k == 2);
      bus.paramLoad   = (mid_load && k == 1);
      if (mid_valid && k == 2) begin
        bus.leftSampleIn  = 16'sd12345;
        bus.rightSampleIn = -16'sd12345;
      end
    end
    bus.sampleValid = 1'b0;
    bus.paramLoad   = 1'b0;
  endtask

  initial begin
    logic signed [15:0] v;
    logic signed [15:0] g;
    reset             = 1'b1;
    bus.sampleValid   = 1'b1;
    bus.leftSampleIn  = 16'sd77;
    bus.rightSampleIn = 16'sd77;
    bus.paramLoad     = 1'b0;
    bus.gainIn        = '0;
    bus.thresholdIn   = '0;
    bus.modeIn        = '0;
    repeat (3) @(negedge clk);
    reset           = 1'b0;
    bus.sampleValid = 1'b0;
    @(negedge clk);
    check("rst_outvalid", bus.outValid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_gain", bus.activeGain, 0);
    check("rst_left", bus.leftSampleOut, 0);
    check("rst_right", bus.rightSampleOut, 0);

    // Reset defaults: bypass mode
    do_sample(16'sd1000, -16'sd1000, 16'sd1000, -16'sd1000, 16'sd0, 0, 0);

    // Gain ramp from 0 toward 10 in steps of 4
    load(16'sd10, 32'sd32767, 2'd0);
    do_sample(16'sd1, 16'sd2, 16'sd1, 16'sd2, 16'sd4, 0, 0);
    do_sample(16'sd3, 16'sd4, 16'sd3, 16'sd4, 16'sd8, 0, 0);
    do_sample(16'sd5, 16'sd6, 16'sd5, 16'sd6, 16'sd10, 0, 0);
    do_sample(16'sd7, 16'sd8, 16'sd7, 16'sd8, 16'sd10, 0, 0);

    // Load on the same edge as the strobe: clip mode, gain steps down 10 -> 8 without undershoot
    bus.paramLoad   = 1'b1;
    bus.gainIn      = 16'sd8;
    bus.thresholdIn = 32'sd16000;
    bus.modeIn      = 2'd1;
    do_sample(16'sd3000, -16'sd3000, 16'sd16000, -16'sd16000, 16'sd8, 0, 0);
    do_sample(16'sd100, -16'sd100, 16'sd800, -16'sd800, 16'sd8, 0, 0);

    // Threshold above 32767 saturates; mode 3 behaves as clip
    load(16'sd8, 32'sd100000, 2'd3);
    do_sample(16'sd5000, -16'sd5000, 16'sd32767, -16'sd32767, 16'sd8, 0, 0);

    // Negative threshold captured as zero
    load(16'sd8, -32'sd5, 2'd1);
    do_sample(16'sd100, -16'sd100, 16'sd0, 16'sd0, 16'sd8, 0, 0);

    // Rectifier, with a bypass/gain-0 load arriving while busy
    load(16'sd8, 32'sd16000, 2'd2);
    bus.gainIn      = 16'sd0;
    bus.thresholdIn = 32'sd32767;
    bus.modeIn      = 2'd0;
    do_sample(-16'sd500, 16'sd700, 16'sd0, 16'sd700, 16'sd8, 1, 0);
    do_sample(-16'sd500, 16'sd700, -16'sd500, 16'sd700, 16'sd4, 0, 0);

    // Strobe during MUL_R is dropped and flagged
    do_sample(16'sd200, -16'sd300, 16'sd200, -16'sd300, 16'sd0, 0, 1);

    // Reset at E2 aborts the sample
    bus.sampleValid   = 1'b1;
    bus.leftSampleIn  = 16'sd1000;
    bus.rightSampleIn = 16'sd1000;
    @(negedge clk);
    bus.sampleValid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_gain", bus.activeGain, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_outvalid", bus.outValid, 0);
      check("abort_left", bus.leftSampleOut, 0);
      check("abort_right", bus.rightSampleOut, 0);
    end
    do_sample(16'sd1000, -16'sd1000, 16'sd1000, -16'sd1000, 16'sd0, 0, 0);

    // Gain request above MAX_GAIN clamps to 128
    load(16'sd1000, 32'sd32767, 2'd0);
    for (int i = 1; i <= 33; i++) begin
      v = 16'(i * 10);
      g = (i * 4 > 128) ? 16'sd128 : 16'(i * 4);
      do_sample(v, -v, v, -v, g, 0, 0);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/distortion_scheduler.md
DISTORTION_SCHEDULER -- requirements
Module: distortion_scheduler

Interface
REQ-001 Parameter GAIN_STEP, default 4, gain increment applied per accepted sample while ramping.
REQ-002 Parameter MAX_GAIN, default 128, upper clamp for target and active gain.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sampleValid  input  1  one-cycle strobe; new stereo sample present.
REQ-006 leftSampleIn / rightSampleIn  input  16 signed  input samples.
REQ-007 paramLoad  input  1  one-cycle strobe; capture gainIn, thresholdIn, modeIn into shadow registers.
REQ-008 gainIn  input  16 signed  requested gain numerator 0..MAX_GAIN.
REQ-009 thresholdIn  input  32 signed  clip threshold.
REQ-010 modeIn  input  2  0 bypass, 1/3 clip distortion, 2 rectifier.
REQ-011 leftSampleOut / rightSampleOut  output  16 signed  processed samples, registered.
REQ-012 outValid  output  1  one-cycle pulse; outputs updated.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 overrun  output  1  one-cycle pulse; sampleValid dropped.
REQ-015 activeGain  output  16 signed  gain currently applied.

Function
REQ-016 FSM states IDLE, MUL_L, MUL_R, OUT; one state per cycle, no stalls.
REQ-017 IDLE: sampleValid high at edge E0 -> latch both samples, commit shadow parameters, go MUL_L.
REQ-018 MUL_L (edge E1): one shared 16x16 signed multiplier computes latched left * activeGain into 32-bit register; go MUL_R.
REQ-019 MUL_R (edge E2): same multiplier computes right * activeGain; go OUT.
REQ-020 OUT (edge E3): register clipped/rectified/bypassed results, pulse outValid, go IDLE; fixed latency 4 edges from strobe capture to outValid high.
REQ-021 sampleValid while busy (edges E1..E3) -> sample discarded, overrun pulses next cycle, pipeline unaffected.
REQ-022 Commit at E0: mode and threshold take shadow values immediately; activeGain moves toward shadow gain by GAIN_STEP, never overshoots target.
REQ-023 Shadow gain clamped to 0..MAX_GAIN at capture; negative thresholdIn captured as 0.
REQ-024 paramLoad and sampleValid on same edge -> capture happens first; the new values are committed for that sample.
REQ-025 paramLoad while busy -> shadow updated; active values unchanged until next acceptance.
REQ-026 Mode 0: output = latched input, product ignored.
REQ-027 Mode 1/3: p > thr -> thr[15:0]; p < -thr -> -thr[15:0]; else saturate p to -32768..32767; thr > 32767 treated as 32767.
REQ-028 Mode 2: negative input -> 0, else input unchanged; gain not applied.
REQ-029 Left and right processed with identical parameters within one sample.

Reset
REQ-030 reset high at an edge -> state IDLE, outputs 0, outValid/overrun/busy 0, activeGain 0, shadow gain 0, threshold 32767, mode 0.
REQ-031 reset mid-operation aborts the sample; no outValid for it; reset has priority over all strobes.

Verification
REQ-032 Mode 0, sample (1000, -1000) -> outValid 4 edges later, outputs (1000, -1000).
REQ-033 Mode 1, gain target 8 preloaded as activeGain 8, thr 16000, inputs (3000, -3000) -> outputs (16000, -16000); inputs (100, -100) -> (800, -800).
REQ-034 Mode 2, inputs (-500, 700) -> outputs (0, 700).
REQ-035 From reset, paramLoad gain 10, GAIN_STEP 4, three samples -> activeGain 4, 8, 10; fourth stays 10.
REQ-036 sampleValid at E0 and E2 -> one outValid, overrun pulses once, busy low after E3.
REQ-037 reset asserted at E2 -> no outValid, all outputs 0, next strobe processes normally.
